// File: rtl/demux_seq_pkg.sv
// demux_seq_pkg: shared types and helpers for the demux select sequencer.
//   CH_NUM       number of demux output channels
//   ch_t         channel index {s1,s0}
//   seq_state_t  sequencer FSM states
//   seq_entry_t  FIFO entry {addr, data}
//   rr_pick      first enabled channel at or after a pointer, with wrap
package demux_seq_pkg;

  localparam int unsigned CH_NUM = 4;

  typedef logic [1:0] ch_t;

  typedef enum logic [0:0] {
    IDLE = 1'b0,
    HOLD = 1'b1
  } seq_state_t;

  typedef struct packed {
    ch_t  addr;
    logic data;
  } seq_entry_t;

  // Returns ptr itself when no channel is enabled; callers qualify with |mask.
  function automatic ch_t rr_pick(ch_t ptr, logic [CH_NUM-1:0] mask);
    ch_t  pick;
    logic found;
    pick  = ptr;
    found = 1'b0;
    for (int unsigned i = 0; i < CH_NUM; i++) begin
      ch_t c;
      c = ptr + ch_t'(i);
      if (!found && mask[c]) begin
        pick  = c;
        found = 1'b1;
      end
    end
    return pick;
  endfunction

endpackage

// File: rtl/demux_seq_fifo.sv
// demux_seq_fifo: synchronous FIFO of seq_entry_t.
//   clk, rst_n   clock, asynchronous active-low reset (flushes contents)
//   push, pop    write / read strobes; push while full is accepted only with pop
//   wr_data      entry to write
//   rd_data      head entry (valid when !empty)
//   full, empty  status
//   level        entries stored, 0..DEPTH
module demux_seq_fifo
  import demux_seq_pkg::*;
#(
  parameter int unsigned DEPTH = 4
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   push,
  input  logic                   pop,
  input  seq_entry_t             wr_data,
  output seq_entry_t             rd_data,
  output logic                   full,
  output logic                   empty,
  output logic [$clog2(DEPTH):0] level
);

  localparam int unsigned AW = $clog2(DEPTH);

  seq_entry_t      mem [DEPTH];
  logic [AW-1:0]   wr_ptr;
  logic [AW-1:0]   rd_ptr;
  logic            do_push;
  logic            do_pop;

  assign full    = (level == (AW+1)'(DEPTH));
  assign empty   = (level == '0);
  assign do_pop  = pop && !empty;
  assign do_push = push && (!full || do_pop);
  assign rd_data = mem[rd_ptr];

  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= wr_data;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      level  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + 1'b1;
      if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
      case ({do_push, do_pop})
        2'b10:   level <= level + 1'b1;
        2'b01:   level <= level - 1'b1;
        default: level <= level;
      endcase
    end
  end

endmodule

// File: rtl/demux_sel_sequencer.sv
// demux_sel_sequencer: buffers 1-bit samples and presents each on d/s1/s0
// for HOLD_CYCLES cycles to drive a 1:4 demux.
//   clk, rst_n   clock, asynchronous active-low reset
//   in_valid     sample offered; accepted when in_valid && in_ready
//   in_ready     FIFO not full
//   in_data      sample bit
//   in_addr      target channel (addressed mode)
//   rr_mode      1 = round-robin channel pointer, 0 = in_addr; sampled at pop
//   ch_mask      channel enables (only with DEMUX_SEQ_MASK_EN)
//   d, s1, s0    registered demux data / selects
//   out_active   a sample is being held
//   fifo_level   entries buffered
// Build option DEMUX_SEQ_MASK_EN adds ch_mask: masked entries are dropped in
// addressed mode, skipped over in round-robin mode.
module demux_sel_sequencer
  import demux_seq_pkg::*;
#(
  parameter int unsigned DEPTH       = 4,
  parameter int unsigned HOLD_CYCLES = 4
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   in_valid,
  output logic                   in_ready,
  input  logic                   in_data,
  input  logic [1:0]             in_addr,
  input  logic                   rr_mode,
`ifdef DEMUX_SEQ_MASK_EN
  input  logic [3:0]             ch_mask,
`endif
  output logic                   d,
  output logic                   s1,
  output logic                   s0,
  output logic                   out_active,
  output logic [$clog2(DEPTH):0] fifo_level
);

  localparam int unsigned CW = (HOLD_CYCLES > 1) ? $clog2(HOLD_CYCLES) : 1;

  seq_state_t           state;
  logic [CW-1:0]        cnt;
  ch_t                  rr_ptr;
  seq_entry_t           wr_entry;
  seq_entry_t           head;
  logic                 full;
  logic                 empty;
  logic                 push;
  logic                 pop;
  logic                 start;
  logic [CH_NUM-1:0]    en_mask;
  ch_t                  sel_ch;
  logic                 sel_ok;

`ifdef DEMUX_SEQ_MASK_EN
  assign en_mask = ch_mask;
`else
  assign en_mask = '1;
`endif

  assign in_ready = !full;
  assign push     = in_valid && in_ready;
  assign wr_entry = '{addr: in_addr, data: in_data};

  demux_seq_fifo #(.DEPTH(DEPTH)) u_fifo (
    .clk     (clk),
    .rst_n   (rst_n),
    .push    (push),
    .pop     (pop),
    .wr_data (wr_entry),
    .rd_data (head),
    .full    (full),
    .empty   (empty),
    .level   (fifo_level)
  );

  always_comb begin
    sel_ch = head.addr;
    sel_ok = en_mask[head.addr];
    if (rr_mode) begin
      sel_ch = rr_pick(rr_ptr, en_mask);
      sel_ok = |en_mask;
    end
  end

  // Pop whenever idle or the current hold expires; a popped entry whose
  // channel is disabled is discarded (start stays low).
  assign pop   = !empty && ((state == IDLE) || (cnt == '0));
  assign start = pop && sel_ok;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= IDLE;
      cnt        <= '0;
      rr_ptr     <= '0;
      d          <= 1'b0;
      s1         <= 1'b0;
      s0         <= 1'b0;
      out_active <= 1'b0;
    end else begin
      if (pop && rr_mode && sel_ok) rr_ptr <= sel_ch + 2'd1;
      if (start) begin
        d          <= head.data;
        {s1, s0}   <= sel_ch;
        out_active <= 1'b1;
        cnt        <= CW'(HOLD_CYCLES - 1);
        state      <= HOLD;
      end else if (state == HOLD) begin
        if (cnt != '0) begin
          cnt <= cnt - 1'b1;
        end else begin
          // Hold expired with nothing to show (FIFO empty or entry dropped);
          // selects keep their last value.
          d          <= 1'b0;
          out_active <= 1'b0;
          state      <= IDLE;
        end
      end
    end
  end

endmodule

// File: tb/tb_demux_sel_sequencer.sv
// tb_demux_sel_sequencer: directed bench with an expected-sample scoreboard.
module tb_demux_sel_sequencer;

  localparam int unsigned DEPTH = 4;
  localparam int unsigned HOLD  = 4;

  typedef struct packed {
    logic [1:0] ch;
    logic       data;
  } req_t;

  logic       clk      = 1'b0;
  logic       rst_n    = 1'b0;
  logic       in_valid = 1'b0;
  logic       in_data  = 1'b0;
  logic [1:0] in_addr  = 2'd0;
  logic       rr_mode  = 1'b0;
`ifdef DEMUX_SEQ_MASK_EN
  logic [3:0] ch_mask  = 4'hF;
`endif
  logic       in_ready;
  logic       d, s1, s0, out_active;
  logic [$clog2(DEPTH):0] fifo_level;

  always #5 clk = ~clk;

  demux_sel_sequencer #(.DEPTH(DEPTH), .HOLD_CYCLES(HOLD)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .in_data    (in_data),
    .in_addr    (in_addr),
    .rr_mode    (rr_mode),
`ifdef DEMUX_SEQ_MASK_EN
    .ch_mask    (ch_mask),
`endif
    .d          (d),
    .s1         (s1),
    .s0         (s0),
    .out_active (out_active),
    .fifo_level (fifo_level)
  );

  int         n_assert = 0;
  int         n_fail   = 0;
  req_t       sb[$];
  req_t       cur;
  int         held     = 0;
  int         run      = 0;
  int         last_run = 0;
  logic [1:0] last_ch  = 2'd0;
  logic [1:0] model_ptr = 2'd0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] req);
    n_assert++;
    assert (obs === req) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, req);
    end
  endtask

  function automatic logic [1:0] pick(input logic [1:0] ptr, input logic [3:0] mask);
    for (int i = 0; i < 4; i++) begin
      logic [1:0] c;
      c = ptr + 2'(i);
      if (mask[c]) return c;
    end
    return ptr;
  endfunction

  // Output checker, evaluated once per cycle on the falling edge.
  task automatic monitor();
    if (out_active === 1'b1) begin
      run++;
      if (held == 0) begin
        if (sb.size() == 0) begin
          n_assert++;
          n_fail++;
          $error("FAIL unexpected_sample: observed ch %0d d %0b expected none", {s1, s0}, d);
          cur.ch   = {s1, s0};
          cur.data = d;
        end else begin
          cur = sb.pop_front();
        end
      end
      chk("sel", {30'd0, s1, s0}, {30'd0, cur.ch});
      chk("data", {31'd0, d}, {31'd0, cur.data});
      last_ch = cur.ch;
      held++;
      if (held == int'(HOLD)) held = 0;
    end else begin
      if (run != 0) begin
        last_run = run;
        run = 0;
      end
      if (held != 0) begin
        n_assert++;
        n_fail++;
        $error("FAIL hold_len: observed %0d cycles expected %0d", held, HOLD);
        held = 0;
      end
      chk("d_idle", {31'd0, d}, 32'd0);
      chk("sel_keep", {30'd0, s1, s0}, {30'd0, last_ch});
    end
  endtask

  task automatic tick();
    @(negedge clk);
    monitor();
  endtask

  // Offers one sample until accepted, then records the expected output.
  task automatic push_item(input logic dat, input logic [1:0] addr);
    logic       ok;
    logic [3:0] en;
    logic [1:0] c;
    req_t       e;
    ok = 1'b0;
    in_valid = 1'b1;
    in_data  = dat;
    in_addr  = addr;
    for (int i = 0; i < 50 && !ok; i++) begin
      ok = (in_ready === 1'b1);
      tick();
    end
    in_valid = 1'b0;
    if (!ok) begin
      n_assert++;
      n_fail++;
      $error("FAIL push_timeout: observed in_ready 0 expected 1");
    end else begin
`ifdef DEMUX_SEQ_MASK_EN
      en = ch_mask;
`else
      en = 4'hF;
`endif
      if (rr_mode) begin
        if (en != 4'd0) begin
          c = pick(model_ptr, en);
          model_ptr = c + 2'd1;
          e.ch = c;
          e.data = dat;
          sb.push_back(e);
        end
      end else if (en[addr]) begin
        e.ch = addr;
        e.data = dat;
        sb.push_back(e);
      end
    end
  endtask

  task automatic wait_idle(input string tag);
    int k;
    k = 0;
    while (!(out_active === 1'b0 && fifo_level == '0) && k < 300) begin
      tick();
      k++;
    end
    if (k >= 300) begin
      n_assert++;
      n_fail++;
      $error("FAIL %s_timeout: observed busy expected idle", tag);
    end
    tick();
    if (sb.size() != 0) begin
      n_assert++;
      n_fail++;
      $error("FAIL %s_missing: observed %0d samples pending expected 0", tag, sb.size());
      sb.delete();
    end
  endtask

  task automatic wait_empty(input string tag);
    int k;
    k = 0;
    while (fifo_level != '0 && k < 100) begin
      tick();
      k++;
    end
    if (k >= 100) begin
      n_assert++;
      n_fail++;
      $error("FAIL %s_timeout: observed level %0d expected 0", tag, fifo_level);
    end
  endtask

  initial begin
    // Reset state
    tick();
    tick();
    chk("rst_d", {31'd0, d}, 32'd0);
    chk("rst_sel", {30'd0, s1, s0}, 32'd0);
    chk("rst_active", {31'd0, out_active}, 32'd0);
    chk("rst_level", 32'(fifo_level), 32'd0);
    chk("rst_ready", {31'd0, in_ready}, 32'd1);
    rst_n = 1'b1;
    tick();

    // 1. Addressed single sample, latency and 4-cycle hold
    rr_mode = 1'b0;
    push_item(1'b1, 2'd2);
    chk("latency_pre", {31'd0, out_active}, 32'd0);
    tick();
    chk("latency", {31'd0, out_active}, 32'd1);
    wait_idle("t1");
    chk("t1_run", 32'(last_run), 32'(HOLD));
    chk("t1_sel_after", {30'd0, s1, s0}, 32'd2);

    // 2. Round-robin, five back-to-back samples
    rr_mode = 1'b1;
    for (int i = 0; i < 5; i++) push_item(1'b1, 2'd3);
    wait_idle("t2");
    chk("t2_back_to_back", 32'(last_run), 32'(5 * HOLD));

    // 3. FIFO full and stall
    rr_mode = 1'b0;
    push_item(1'b1, 2'd1);
    push_item(1'b0, 2'd2);
    chk("t3_pushpop_level", 32'(fifo_level), 32'd1);
    push_item(1'b1, 2'd3);
    push_item(1'b1, 2'd0);
    push_item(1'b0, 2'd1);
    chk("t3_full_level", 32'(fifo_level), 32'(DEPTH));
    chk("t3_full_ready", {31'd0, in_ready}, 32'd0);
    push_item(1'b1, 2'd2);
    chk("t3_refill_level", 32'(fifo_level), 32'(DEPTH));
    wait_idle("t3");

    // 4. Reset in the middle of a hold
    push_item(1'b1, 2'd3);
    push_item(1'b1, 2'd1);
    tick();
    rst_n = 1'b0;
    #1;
    chk("t4_d", {31'd0, d}, 32'd0);
    chk("t4_sel", {30'd0, s1, s0}, 32'd0);
    chk("t4_active", {31'd0, out_active}, 32'd0);
    chk("t4_level", 32'(fifo_level), 32'd0);
    sb.delete();
    held = 0;
    run = 0;
    last_ch = 2'd0;
    model_ptr = 2'd0;
    tick();
    tick();
    rst_n = 1'b1;
    repeat (8) tick();
    chk("t4_no_stale", 32'(fifo_level), 32'd0);

    // 5. Mode switching keeps the round-robin pointer
    rr_mode = 1'b1;
    push_item(1'b1, 2'd2);
    wait_empty("t5a");
    push_item(1'b0, 2'd2);
    wait_empty("t5b");
    rr_mode = 1'b0;
    push_item(1'b1, 2'd3);
    wait_empty("t5c");
    rr_mode = 1'b1;
    push_item(1'b1, 2'd0);
    wait_idle("t5");
    chk("t5_last_sel", {30'd0, s1, s0}, 32'd2);

`ifdef DEMUX_SEQ_MASK_EN
    // 6. Channel mask
    rst_n = 1'b0;
    tick();
    rst_n = 1'b1;
    last_ch = 2'd0;
    model_ptr = 2'd0;
    tick();
    ch_mask = 4'b1010;
    rr_mode = 1'b1;
    for (int i = 0; i < 3; i++) push_item(1'b1, 2'd0);
    wait_idle("t6");
    chk("t6_last_sel", {30'd0, s1, s0}, 32'd1);
    rr_mode = 1'b0;
    push_item(1'b1, 2'd0);
    chk("t6_drop_queued", 32'(fifo_level), 32'd1);
    tick();
    chk("t6_drop_level", 32'(fifo_level), 32'd0);
    chk("t6_drop_active", {31'd0, out_active}, 32'd0);
    repeat (3) tick();
`endif

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
